// File: rtl/ofifo_drain_pkg.sv
// Shared constants and state encoding for the ofifo drain path.
package ofifo_drain_pkg;

    localparam int COL_DEF    = 8;
    localparam int BW_DEF     = 16;
    localparam int ADDR_W_DEF = 11;
    localparam int CNT_W_DEF  = 11;
    localparam int RD_LAT_DEF = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_WRITE = ST_WRITE,
        S_FIN   = ST_FIN
    } drain_state_e;

endpackage

// File: rtl/ofifo_drain_relu.sv
// Per-lane ReLU on a packed row; negative lanes become zero, others pass unchanged.
module drain_relu
    import ofifo_drain_pkg::*;
#(
    parameter int col = COL_DEF,
    parameter int bw  = BW_DEF
) (
    input  logic              en,
    input  logic [col*bw-1:0] din,
    output logic [col*bw-1:0] dout
);

    always_comb begin
        dout = din;
        for (int i = 0; i < col; i++) begin
            if (en && din[i*bw + bw - 1]) begin
                dout[i*bw +: bw] = '0;
            end
        end
    end

endmodule

// File: rtl/ofifo_drain.sv
// Drains row_cnt rows from the ofifo, optionally ReLUs them, and writes them to
// consecutive psum SRAM addresses. One read in flight; all outputs registered.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | waiting for f_valid, then pulses rd
// WAIT  | read latency countdown
// WRITE | f_out holds the row; captured into the SRAM write registers
// FIN   | pulses done, drops busy
module ofifo_drain
    import ofifo_drain_pkg::*;
#(
    parameter int col    = COL_DEF,
    parameter int bw     = BW_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  row_cnt,
    input  logic              relu_en,
    input  logic              f_valid,
    input  logic [col*bw-1:0] f_out,
    output logic              rd,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [col*bw-1:0] sram_d,
    output logic              busy,
    output logic              done
);

    localparam int LAT_W = $clog2(RD_LAT + 1);
    // rd is registered, so the WAIT countdown covers only RD_LAT-1 further cycles
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    drain_state_e      state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              relu_q, relu_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic              rd_d, cen_d, wen_d, busy_d, done_d;
    logic [ADDR_W-1:0] sram_addr_d;
    logic [col*bw-1:0] sram_d_d;
    logic [col*bw-1:0] relu_out;

    drain_relu #(
        .col (col),
        .bw  (bw)
    ) u_relu (
        .en   (relu_q),
        .din  (f_out),
        .dout (relu_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            relu_q    <= 1'b0;
            lat_q     <= '0;
            rd        <= 1'b0;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_d    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            relu_q    <= relu_d;
            lat_q     <= lat_d;
            rd        <= rd_d;
            sram_cen  <= cen_d;
            sram_wen  <= wen_d;
            sram_addr <= sram_addr_d;
            sram_d    <= sram_d_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        remain_d    = remain_q;
        relu_d      = relu_q;
        lat_d       = lat_q;
        rd_d        = 1'b0;
        cen_d       = 1'b1;
        wen_d       = 1'b1;
        sram_addr_d = sram_addr;
        sram_d_d    = sram_d;
        busy_d      = busy;
        done_d      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (row_cnt != '0) begin
                        state_d  = S_ISSUE;
                        addr_d   = base_addr;
                        remain_d = row_cnt;
                        relu_d   = relu_en;
                        busy_d   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (f_valid) begin
                    rd_d    = 1'b1;
                    lat_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_WRITE: begin
                cen_d       = 1'b0;
                wen_d       = 1'b0;
                sram_addr_d = addr_q;
                sram_d_d    = relu_out;
                addr_d      = addr_q + ADDR_W'(1);
                remain_d    = remain_q - CNT_W'(1);
                state_d     = (remain_q == CNT_W'(1)) ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed-plus-random bench for ofifo_drain with an ofifo responder and a write scoreboard.
module tb_ofifo_drain;

    localparam int COL    = 8;
    localparam int BW     = 16;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 11;
    localparam int RD_LAT = 3;
    localparam int W      = COL * BW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  row_cnt;
    logic              relu_en;
    logic              f_valid;
    logic [W-1:0]      f_out = '0;
    logic              rd;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [W-1:0]      sram_d;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] rows [0:511];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    int           underflow = 0;
    logic         fv_en = 1'b0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [W-1:0]      exp_data[$];

    assign f_valid = fv_en && (wr_ptr != rd_ptr);

    ofifo_drain #(
        .col    (COL),
        .bw     (BW),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .row_cnt   (row_cnt),
        .relu_en   (relu_en),
        .f_valid   (f_valid),
        .f_out     (f_out),
        .rd        (rd),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_d    (sram_d),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] pattern_row();
        logic [15:0]  pat [4];
        logic [W-1:0] o;
        pat = '{16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF};
        o = '0;
        for (int i = 0; i < COL; i++) o[i*BW +: BW] = pat[i % 4];
        return o;
    endfunction

    // Reference ReLU: a lane is negative when read as a signed 16-bit integer.
    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] r, input bit en);
        logic [W-1:0]       o;
        logic signed [15:0] lane;
        for (int i = 0; i < COL; i++) begin
            lane = r[i*BW +: BW];
            o[i*BW +: BW] = (en && lane < 0) ? 16'h0000 : r[i*BW +: BW];
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd"},   rd,        1'b0);
        chk({tag, "_cen"},  sram_cen,  1'b1);
        chk({tag, "_wen"},  sram_wen,  1'b1);
        chk({tag, "_addr"}, sram_addr, '0);
        chk({tag, "_d"},    sram_d,    '0);
        chk({tag, "_busy"}, busy,      1'b0);
        chk({tag, "_done"}, done,      1'b0);
    endtask

    // ofifo responder: pops a row on rd, presents it exactly RD_LAT cycles later, then scrambles f_out.
    always begin : ofifo_model
        logic [W-1:0] row;
        @(negedge clk);
        if (rd === 1'b1) begin
            row = rand_row();
            if (rd_ptr == wr_ptr) underflow++;
            else begin
                row = rows[rd_ptr];
                rd_ptr++;
            end
            repeat (RD_LAT) @(posedge clk);
            #1 f_out = row;
            @(posedge clk);
            #1 f_out = rand_row();
        end
    end

    task automatic run_rows(input logic [ADDR_W-1:0] base, input int cnt, input bit relu,
                            input bit pat, input int stall_at, input int restart_at,
                            input bit spacing);
        logic [W-1:0]      r, last_d;
        logic [ADDR_W-1:0] last_a;
        int cyc, nw, last_rd, last_wr, stall_left, budget;
        bit got_done;
        for (int k = 0; k < cnt; k++) begin
            r = (pat && k == 0) ? pattern_row() : rand_row();
            rows[wr_ptr] = r;
            wr_ptr++;
            exp_addr.push_back(ADDR_W'((int'(base) + k) % 2048));
            exp_data.push_back(relu_ref(r, relu));
        end
        start = 1'b1; base_addr = base; row_cnt = CNT_W'(cnt); relu_en = relu;
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_W'($urandom); row_cnt = CNT_W'($urandom); relu_en = 1'($urandom);
        budget = cnt * (RD_LAT + 2) + 40;
        cyc = 1; nw = 0; last_rd = -100; last_wr = -100; stall_left = 0; got_done = 0;
        last_a = '0; last_d = '0;
        while (!got_done && cyc < budget) begin
            start = (cyc == restart_at);
            if (start) begin
                base_addr = ADDR_W'($urandom);
                row_cnt = CNT_W'($urandom_range(1, 50));
            end
            if (stall_left > 0) begin
                chk("stall_rd", rd, 1'b0);
                chk("stall_cen", sram_cen, 1'b1);
                stall_left--;
                if (stall_left == 0) fv_en = 1'b1;
            end
            if (rd === 1'b1) begin
                if (spacing && last_rd > 0) chk("rd_spacing", cyc - last_rd, RD_LAT + 2);
                last_rd = cyc;
            end
            if (sram_cen === 1'b0) begin
                chk("wr_latency", cyc - last_rd, RD_LAT + 1);
                chk("wr_wen", sram_wen, 1'b0);
                if (exp_addr.size() == 0) chk("extra_write", nw + 1, cnt);
                else begin
                    chk("wr_addr", sram_addr, exp_addr.pop_front());
                    chk("wr_data", sram_d, exp_data.pop_front());
                end
                nw++;
                last_wr = cyc; last_a = sram_addr; last_d = sram_d;
                if (nw == stall_at) begin
                    fv_en = 1'b0;
                    stall_left = 10;
                end
            end else if (nw > 0) begin
                chk("addr_hold", sram_addr, last_a);
                chk("data_hold", sram_d, last_d);
            end
            if (done === 1'b1) begin
                got_done = 1;
                chk("done_timing", cyc - last_wr, 1);
                chk("n_writes", nw, cnt);
                chk("busy_at_done", busy, 1'b0);
            end else begin
                chk("busy_run", busy, 1'b1);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        fv_en = 1'b1;
        if (!got_done) chk("done_timeout", got_done, 1'b1);
        chk("done_one_cycle", done, 1'b0);
        chk("ofifo_underflow", underflow, 0);
    endtask

    initial begin
        int waited;
        bit seen;
        reset = 1'b1; start = 1'b0; base_addr = '0; row_cnt = '0; relu_en = 1'b0;
        #2 reset = 1'b0;

        // 1: reset held with random inputs, then release
        for (int k = 0; k < 3; k++) begin rows[wr_ptr] = rand_row(); wr_ptr++; end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom); base_addr = ADDR_W'($urandom); row_cnt = CNT_W'($urandom);
            relu_en = 1'($urandom); fv_en = 1'($urandom);
            chk_reset_vals("in_reset");
        end
        @(negedge clk);
        start = 1'b0; fv_en = 1'b0; reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_rd", rd, 1'b0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_cen", sram_cen, 1'b1);
        end
        wr_ptr = rd_ptr;
        fv_en = 1'b1;

        // 2: plain run, bit-exact data
        run_rows(11'h010, 4, 1'b0, 1'b0, -1, -1, 1'b1);
        // 3: ReLU with the sign-boundary pattern
        run_rows(ADDR_W'($urandom), 4, 1'b1, 1'b1, -1, -1, 1'b1);
        // 4: f_valid stall after the second write
        run_rows(11'h100, 6, 1'($urandom), 1'b0, 2, -1, 1'b0);
        // 5: address wrap, then a zero-length request
        run_rows(11'h7FE, 3, 1'b0, 1'b0, -1, -1, 1'b1);
        start = 1'b1; row_cnt = '0; base_addr = ADDR_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1'b1);
        chk("zero_rd", rd, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("zero_after_done", done, 1'b0);
            chk("zero_after_rd", rd, 1'b0);
            chk("zero_after_cen", sram_cen, 1'b1);
        end

        // 6: reset one cycle after an rd aborts the run
        for (int k = 0; k < 4; k++) begin rows[wr_ptr] = rand_row(); wr_ptr++; end
        start = 1'b1; base_addr = 11'h200; row_cnt = 11'd4; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        seen = 0; waited = 0;
        while (!seen && waited < 20) begin
            if (rd === 1'b1) seen = 1;
            else begin @(negedge clk); waited++; end
        end
        if (!seen) chk("abort_rd_timeout", seen, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1 chk_reset_vals("abort");
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_cen", sram_cen, 1'b1);
            chk("abort_hold_done", done, 1'b0);
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_abort_cen", sram_cen, 1'b1);
            chk("post_abort_done", done, 1'b0);
            chk("post_abort_rd", rd, 1'b0);
        end
        wr_ptr = rd_ptr;
        exp_addr.delete();
        exp_data.delete();

        // new run after release, with a start pulse while busy
        run_rows(ADDR_W'($urandom), 5, 1'b1, 1'b0, -1, 3, 1'b1);
        for (int t = 0; t < 3; t++)
            run_rows(ADDR_W'($urandom), $urandom_range(1, 5), 1'($urandom), 1'b0, -1, -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
